temporizador_regressivo: RTL and testbench

//   Loadable modulo-M down-counting timer: the counting-down counterpart of the
//   up counter contador_m. The control unit loads a duration, then enables it

---
 rtl/temporizador_pkg.sv | 14 +
 rtl/temporizador_regressivo.sv | 120 ++++++++++++
 tb/tb_temporizador_regressivo.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/temporizador_pkg.sv
// Shared definitions for the down-counting timer: state codes and state width.
package temporizador_pkg;

    localparam int ESTADO_W = 2;

    typedef logic [ESTADO_W-1:0] estado_t;

    // PAUSADO is not a separate code: it is CARREGADO with Q != carga.
    localparam estado_t OCIOSO    = 2'd0;
    localparam estado_t CARREGADO = 2'd1;
    localparam estado_t CONTANDO  = 2'd2;
    localparam estado_t ESGOTADO  = 2'd3;

endpackage

// File: rtl/temporizador_regressivo.sv
// Loadable modulo-M down-counting timer with half-time (meio) and expiry (fim)
// indications for the control unit.
// Optional feature macro: RECARGA_AUTO_EN (periodic mode: on expiry the count
// reloads from carga and keeps running). Undefined: one-shot mode.
module temporizador_regressivo
    import temporizador_pkg::*;
#(
    parameter int M = 5000,   // modulus; largest loadable value is M-1
    parameter int N = 13      // counter width; 2**N must be >= M
) (
    input  logic                clock,
    input  logic                zera_as_n,
    input  logic                zera_s,
    input  logic                carrega,
    input  logic [N-1:0]        valor,
    input  logic                conta,
    output logic [N-1:0]        Q,
    output logic                fim,
    output logic                meio,
    output logic                ocupado,
    output logic [ESTADO_W-1:0] estado
);

    localparam logic [N-1:0] VALOR_MAX = N'(M - 1);
    localparam logic [N-1:0] UM        = N'(1);
    localparam logic [N-1:0] ZERO      = '0;

    estado_t      estado_r, estado_nx;
    logic [N-1:0] q_r, q_nx;
    logic [N-1:0] carga_r, carga_nx;
    logic         fim_r, fim_nx;
    logic [N-1:0] valor_sat;

    // Saturate out-of-range durations to the largest loadable value.
    always_comb begin
        valor_sat = (32'(valor) >= M) ? VALOR_MAX : valor;
    end

    // Next-state, next-count and expiry decision; priority zera_s > carrega > conta.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        estado_nx = estado_r;
        q_nx      = q_r;
        carga_nx  = carga_r;
        fim_nx    = 1'b0;

        if (zera_s) begin
            estado_nx = OCIOSO;
            q_nx      = ZERO;
            carga_nx  = ZERO;
        end else if (carrega) begin
            carga_nx = valor_sat;
            q_nx     = valor_sat;
            if (valor_sat == ZERO) begin
                // A zero duration expires immediately: fim in the next cycle.
                estado_nx = ESGOTADO;
                fim_nx    = 1'b1;
            end else begin
                estado_nx = CARREGADO;
            end
        end else begin
            case (estado_r)
                CARREGADO, CONTANDO: begin
                    if (conta) begin
                        if (q_r == UM) begin
                            fim_nx = 1'b1;
`ifdef RECARGA_AUTO_EN
                            q_nx      = carga_r;
                            estado_nx = CONTANDO;
`else
                            q_nx      = ZERO;
                            estado_nx = ESGOTADO;
`endif
                        end else begin
                            q_nx      = q_r - UM;
                            estado_nx = CONTANDO;
                        end
                    end else begin
                        // Dropping conta pauses: the count is held in CARREGADO.
                        estado_nx = CARREGADO;
                    end
                end
                // OCIOSO and ESGOTADO ignore conta and hold everything.
                default: begin
                    estado_nx = estado_r;
                end
            endcase
        end
    end

    // State, counter, duration and expiry-pulse registers.
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado_r <= OCIOSO;
            q_r      <= ZERO;
            carga_r  <= ZERO;
            fim_r    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            estado_r <= estado_nx;
            q_r      <= q_nx;
            carga_r  <= carga_nx;
            fim_r    <= fim_nx;
        end
    end

    // Output decode. meio is also masked in OCIOSO, where Q and carga are
    // both 0 and would otherwise compare equal.
    always_comb begin
        Q       = q_r;
        fim     = fim_r;
        estado  = estado_r;
        ocupado = (estado_r == CARREGADO) || (estado_r == CONTANDO);
        meio    = (q_r == (carga_r >> 1)) &&
                  (estado_r != ESGOTADO) && (estado_r != OCIOSO);
    end

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Self-checking bench for temporizador_regressivo: directed scenarios plus a
// randomized phase, compared against a behavioural model of remaining time.
`timescale 1ns/1ps
module tb_temporizador_regressivo;

    localparam int M = 5000;
    localparam int N = 13;

    logic         clock = 1'b0;
    logic         zera_as_n = 1'b0;
    logic         zera_s = 1'b0;
    logic         carrega = 1'b0;
    logic [N-1:0] valor = '0;
    logic         conta = 1'b0;
    logic [N-1:0] Q;
    logic         fim;
    logic         meio;
    logic         ocupado;
    logic [1:0]   estado;

    int n_checks = 0;
    int n_errors = 0;

    // Model: remaining time, loaded duration and three plain flags.
    int m_rem   = 0;
    int m_carga = 0;
    bit m_idle  = 1;  // nothing loaded since clear
    bit m_done  = 0;  // time ran out (one-shot)
    bit m_run   = 0;  // last cycle was an enabled decrement
    bit m_fim   = 0;

    // Scenario bookkeeping.
    int fim_count;
    int meio_count;
    int en_count;
    int fim_at;

    temporizador_regressivo #(.M(M), .N(N)) dut (
        .clock     (clock),
        .zera_as_n (zera_as_n),
        .zera_s    (zera_s),
        .carrega   (carrega),
        .valor     (valor),
        .conta     (conta),
        .Q         (Q),
        .fim       (fim),
        .meio      (meio),
        .ocupado   (ocupado),
        .estado    (estado)
    );

    always #10 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        m_rem = 0; m_carga = 0; m_idle = 1; m_done = 0; m_run = 0; m_fim = 0;
    endtask

    task automatic model_step(input bit zs, input bit cr, input int v, input bit ct);
        m_fim = 0;
        if (zs) begin
            model_clear();
        end else if (cr) begin
            m_carga = (v >= M) ? M - 1 : v;
            m_rem   = m_carga;
            m_idle  = 0;
            m_run   = 0;
            m_done  = (m_carga == 0);
            m_fim   = (m_carga == 0);
        end else if (!m_idle && !m_done) begin
            if (ct) begin
                m_run = 1;
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_fim = 1;
`ifdef RECARGA_AUTO_EN
                    m_rem = m_carga;
`else
                    m_done = 1;
`endif
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic compare_all();
        int exp_estado;
        bit busy;
        busy = !m_idle && !m_done;
        exp_estado = m_idle ? 0 : (m_done ? 3 : (m_run ? 2 : 1));
        check("Q",       32'(Q),       m_rem);
        check("estado",  32'(estado),  exp_estado);
        check("fim",     32'(fim),     32'(m_fim));
        check("ocupado", 32'(ocupado), 32'(busy));
        check("meio",    32'(meio),    32'(busy && (m_rem == m_carga / 2)));
    endtask

    // One clock cycle: drive inputs, advance model at the edge, compare #1 later.
    task automatic tick(input bit zs, input bit cr, input int v, input bit ct);
        zera_s  = zs;
        carrega = cr;
        valor   = N'(v);
        conta   = ct;
        @(posedge clock);
        model_step(zs, cr, v, ct);
        #1;
        compare_all();
        if (ct && !zs && !cr) en_count++;
        if (fim) begin
            fim_count++;
            if (fim_at < 0) fim_at = en_count;
        end
        if (meio) meio_count++;
    endtask

    task automatic scen_reset();
        fim_count = 0; meio_count = 0; en_count = 0; fim_at = -1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic async_reset();
        #4;
        zera_as_n = 1'b0;
        #1;
        model_clear();
        compare_all();
        @(posedge clock);
        #1;
        compare_all();
        zera_as_n = 1'b1;
    endtask

    initial begin
        // 1. reset, then conta ignored while idle
        #3;
        compare_all();
        @(posedge clock);
        #1;
        zera_as_n = 1'b1;
        scen_reset();
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 1);
        check("idle_fim_count", fim_count, 0);

        // 2. load 20, count 25
        tick(0, 1, 20, 0);
        check("load20_Q", 32'(Q), 20);
        scen_reset();
        for (int i = 0; i < 25; i++) tick(0, 0, 0, 1);
        check("t2_fim_count", fim_count, 1);
        check("t2_fim_at", fim_at, 20);
        check("t2_meio_count", meio_count, 1);
`ifndef RECARGA_AUTO_EN
        check("t2_final_estado", 32'(estado), 3);
        check("t2_final_Q", 32'(Q), 0);
`endif

        // 3. load 40, count 15, pause 10, count 30
        tick(0, 1, 40, 0);
        scen_reset();
        for (int i = 0; i < 15; i++) tick(0, 0, 0, 1);
        check("t3_Q_before_pause", 32'(Q), 25);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);
        check("t3_Q_paused", 32'(Q), 25);
        check("t3_estado_paused", 32'(estado), 1);
        for (int i = 0; i < 30; i++) tick(0, 0, 0, 1);
        check("t3_fim_at", fim_at, 40);
        check("t3_fim_count", fim_count, 1);

        // 4. saturating load, long count
        tick(0, 1, 6000, 0);
        check("t4_Q_sat", 32'(Q), 4999);
        scen_reset();
        for (int i = 0; i < 5010; i++) tick(0, 0, 0, 1);
        check("t4_fim_count", fim_count, 1);
        check("t4_fim_at", fim_at, 4999);

        // 5. simultaneous clear/load/count, then reload mid-count
        tick(0, 1, 30, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1);
        tick(1, 1, 17, 1);
        check("t5_cleared_Q", 32'(Q), 0);
        check("t5_cleared_estado", 32'(estado), 0);
        tick(0, 1, 30, 0);
        scen_reset();
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 1);
        tick(0, 1, 5, 1);
        check("t5_restart_Q", 32'(Q), 5);
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1);
        check("t5_fim_count", fim_count, 1);
        check("t5_fim_at", fim_at, 15);

        // zero-duration load expires immediately
        tick(0, 1, 0, 0);
        check("zero_load_fim", 32'(fim), 1);
        check("zero_load_estado", 32'(estado), 3);

        // async reset in the middle of a count
        tick(0, 1, 12, 0);
        for (int i = 0; i < 11; i++) tick(0, 0, 0, 1);
        async_reset();

`ifdef RECARGA_AUTO_EN
        // 6. periodic mode: load 8, conta held 30 cycles
        tick(0, 1, 8, 0);
        scen_reset();
        for (int i = 0; i < 30; i++) tick(0, 0, 0, 1);
        check("t6_fim_count", fim_count, 3);
        check("t6_estado", 32'(estado), 2);
`endif

        // randomized phase
        for (int i = 0; i < 1500; i++) begin
            bit zs, cr, ct;
            int v;
            zs = ($urandom_range(0, 63) == 0);
            cr = ($urandom_range(0, 15) == 0);
            ct = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 3);
                1, 2:    v = $urandom_range(0, 40);
                default: v = $urandom_range(0, (1 << N) - 1);
            endcase
            if (i == 700) async_reset();
            tick(zs, cr, v, ct);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
